// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if
//   Register bus between MIO_BUS and the interrupt controller.
//   we       write strobe
//   reg_sel  register select (bus addr[3:2])
//   wdata    write data from the CPU
//   rdata    read data of the selected register (combinational)
interface irq_ctrl_if;
  logic        we;
  logic [1:0]  reg_sel;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output we, output reg_sel, output wdata, input rdata);
  modport slave  (input we, input reg_sel, input wdata, output rdata);
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl
//   Interrupt controller feeding the CPU INT input. Rising edges on the
//   level sources latch into sticky pending bits. The pending bits are
//   gated by a per-source mask and a global enable to drive a registered irq.
//   Ports:
//     clk      system clock, rising edge
//     rst      synchronous active-high reset
//     src      raw interrupt sources (phase-asynchronous to clk)
//     bus      register bus (slave side): we, reg_sel, wdata in; rdata out
//     irq      registered interrupt request to the CPU
//   Registers (reg_sel):
//     0 PENDING  read pending, write-1-to-clear
//     1 MASK     read/write enable per source
//     2 CAUSE    bit31 = any enabled pending, bits[3:0] = lowest index
//     3 CTRL     bit0 GIE (rw), bit1 write-1 clears LOST, bits[31:16] LOST
module irq_ctrl #(
  parameter int N_SRC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  irq_ctrl_if.slave        bus,
  output logic             irq
);

  logic [N_SRC-1:0] s1_reg;
  logic [N_SRC-1:0] s2_reg;
  logic [N_SRC-1:0] pending_reg;
  logic [N_SRC-1:0] pending_next;
  logic [N_SRC-1:0] mask_reg;
  logic             gie_reg;
  logic [15:0]      lost_reg;
  logic [15:0]      lost_next;
  logic             irq_reg;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] active;
  logic             any_active;
  logic             hit;
  logic [3:0]       cause_idx;
  logic [31:0]      rd_data;

  logic wr_pending;
  logic wr_mask;
  logic wr_ctrl;

  // Only the low N_SRC bits of wdata matter for PENDING/MASK.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, bus.wdata};

  assign wr_pending = bus.we && (bus.reg_sel == 2'd0);
  assign wr_mask    = bus.we && (bus.reg_sel == 2'd1);
  assign wr_ctrl    = bus.we && (bus.reg_sel == 2'd3);

  assign rise       = s1_reg & ~s2_reg;
  assign active     = pending_reg & mask_reg;
  assign any_active = |active;

  // A new edge on a bit that is still pending is an interrupt that
  // software will never see separately.
  assign hit = |(rise & pending_reg);

  // Per-bit pending update: a fresh edge beats a simultaneous clear so
  // that no event is lost between software's read and acknowledge.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pending
      assign w1c[gi]          = wr_pending & bus.wdata[gi];
      assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~w1c[gi]);
    end
  endgenerate

  // Clear wins over a coincident increment. The counter saturates.
  always_comb begin
    lost_next = lost_reg;
    if (wr_ctrl && bus.wdata[1]) begin
      lost_next = 16'd0;
    end else if (hit && (lost_reg != 16'hFFFF)) begin
      lost_next = lost_reg + 16'd1;
    end
  end

  // Lowest-numbered active source has priority: scan downwards so the
  // last assignment is the smallest index.
  always_comb begin
    cause_idx = 4'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        cause_idx = 4'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Loading both stages with the live input means a source already
      // high at reset release does not look like a new edge.
      s1_reg      <= src;
      s2_reg      <= src;
      pending_reg <= '0;
      mask_reg    <= '0;
      gie_reg     <= 1'b0;
      lost_reg    <= 16'd0;
      irq_reg     <= 1'b0;
    end else begin
      s1_reg      <= src;
      s2_reg      <= s1_reg;
      pending_reg <= pending_next;
      if (wr_mask) begin
        mask_reg <= bus.wdata[N_SRC-1:0];
      end
      if (wr_ctrl) begin
        gie_reg <= bus.wdata[0];
      end
      lost_reg    <= lost_next;
      // Built from registered state, so irq trails any write by one edge.
      irq_reg     <= gie_reg & any_active;
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (bus.reg_sel)
      2'd0:    rd_data = 32'(pending_reg);
      2'd1:    rd_data = 32'(mask_reg);
      2'd2:    rd_data = {any_active, 27'd0, (any_active ? cause_idx : 4'd0)};
      default: rd_data = {lost_reg, 15'd0, gie_reg};
    endcase
  end

  assign bus.rdata = rd_data;
  assign irq       = irq_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] src;
  logic       irq;

  irq_ctrl_if bus_if ();

  irq_ctrl #(.N_SRC(4)) dut (
    .clk (clk),
    .rst (rst),
    .src (src),
    .bus (bus_if.slave),
    .irq (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  sel;
    logic [31:0] wdata;
    logic [3:0]  src;
    logic [1:0]  chk;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t vq[$];
  int   total;
  int   bad;

  task automatic add(input logic we, input logic [1:0] sel, input logic [31:0] wdata,
                     input logic [3:0] s, input logic [1:0] chk,
                     input logic [31:0] exp_rdata, input logic exp_irq);
    vec_t v;
    v.we = we; v.sel = sel; v.wdata = wdata; v.src = s;
    v.chk = chk; v.exp_rdata = exp_rdata; v.exp_irq = exp_irq;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One rising edge, then settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] sel, output logic [31:0] val);
    bus_if.reg_sel = sel;
    #1;
    val = bus_if.rdata;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] d);
    bus_if.we      = 1'b1;
    bus_if.reg_sel = sel;
    bus_if.wdata   = d;
    tick();
    bus_if.we      = 1'b0;
  endtask

  logic [31:0] r;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    src   = 4'b0001;
    bus_if.we      = 1'b0;
    bus_if.reg_sel = 2'd0;
    bus_if.wdata   = 32'd0;

    // Reset with src[0] held high through release.
    tick();
    tick();
    for (int s = 0; s < 4; s++) begin
      rd(2'(s), r);
      check($sformatf("reset_reg%0d", s), r, 32'd0);
    end
    check("reset_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      rd(2'd0, r);
      check("hold_pending", r, 32'd0);
      check("hold_irq", {31'd0, irq}, 32'd0);
    end
    $display("reset/hold: 20 cycles with src[0] high from release");

    // Vector table: each entry is one edge; chk register read after it.
    add(1, 2'd1, 32'h1,        4'h0, 2'd1, 32'h1,        0); // MASK=1
    add(1, 2'd3, 32'h1,        4'h0, 2'd3, 32'h1,        0); // GIE=1
    add(0, 2'd0, 32'h0,        4'h1, 2'd0, 32'h0,        0); // src0 sampled (t)
    add(0, 2'd0, 32'h0,        4'h0, 2'd0, 32'h1,        0); // pending t+1
    add(0, 2'd0, 32'h0,        4'h0, 2'd2, 32'h8000_0000, 1); // irq t+2
    add(1, 2'd0, 32'h1,        4'h0, 2'd0, 32'h0,        1); // W1C
    add(0, 2'd0, 32'h0,        4'h0, 2'd0, 32'h0,        0); // irq drops
    add(1, 2'd1, 32'hF,        4'h0, 2'd1, 32'hF,        0); // MASK=F
    add(0, 2'd0, 32'h0,        4'h6, 2'd0, 32'h0,        0); // src1,2 sampled
    add(0, 2'd0, 32'h0,        4'h6, 2'd0, 32'h6,        0);
    add(0, 2'd0, 32'h0,        4'h6, 2'd2, 32'h8000_0001, 1);
    add(1, 2'd0, 32'h2,        4'h6, 2'd2, 32'h8000_0002, 1); // clear bit1
    add(1, 2'd0, 32'h4,        4'h0, 2'd0, 32'h0,        1);
    add(0, 2'd0, 32'h0,        4'h0, 2'd2, 32'h0,        0); // cause empty
    add(1, 2'd1, 32'h0,        4'h0, 2'd1, 32'h0,        0); // MASK=0
    add(0, 2'd0, 32'h0,        4'h8, 2'd0, 32'h0,        0);
    add(0, 2'd0, 32'h0,        4'h8, 2'd0, 32'h8,        0); // masked latches
    add(0, 2'd0, 32'h0,        4'h0, 2'd2, 32'h0,        0);
    add(1, 2'd1, 32'h8,        4'h0, 2'd1, 32'h8,        0); // MASK=8
    add(0, 2'd0, 32'h0,        4'h0, 2'd2, 32'h8000_0003, 1);
    add(1, 2'd0, 32'h8,        4'h0, 2'd0, 32'h0,        1);
    add(0, 2'd0, 32'h0,        4'h0, 2'd3, 32'h1,        0);
    add(1, 2'd2, 32'hFFFF_FFFF, 4'h0, 2'd2, 32'h0,       0); // CAUSE ro
    add(1, 2'd3, 32'h3,        4'h0, 2'd3, 32'h1,        0); // bit1 reads 0

    foreach (vq[i]) begin
      bus_if.we      = vq[i].we;
      bus_if.reg_sel = vq[i].sel;
      bus_if.wdata   = vq[i].wdata;
      src            = vq[i].src;
      tick();
      bus_if.we = 1'b0;
      rd(vq[i].chk, r);
      $display("vec %0d: reg%0d=%h irq=%b", i, vq[i].chk, r, irq);
      check($sformatf("vec%0d_rdata", i), r, vq[i].exp_rdata);
      check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vq[i].exp_irq});
    end

    // Edge on pending bit 0 coinciding with its W1C: set wins, LOST=1.
    src = 4'h1; tick();
    src = 4'h0; tick();
    src = 4'h1; tick();
    src = 4'h0; wr(2'd0, 32'h1);
    rd(2'd0, r);
    check("collide_pending", r, 32'h1);
    rd(2'd3, r);
    check("collide_lost", r, 32'h0001_0001);
    $display("collision with W1C: ctrl=%h", r);
    tick();
    tick();

    // Alternate src0/src1 every cycle: every edge from the 4th onward
    // re-hits a pending bit, so LOST = 1 + (K-2) after K edges.
    for (int c = 0; c < 200; c++) begin
      src = (c % 2 == 0) ? 4'h1 : 4'h2;
      tick();
    end
    rd(2'd3, r);
    check("lost_199", r, 32'h00C7_0001);
    $display("lost after 200 toggles: ctrl=%h", r);
    for (int c = 200; c < 66000; c++) begin
      src = (c % 2 == 0) ? 4'h1 : 4'h2;
      tick();
    end
    rd(2'd3, r);
    check("lost_sat", r, 32'hFFFF_0001);
    $display("lost saturated: ctrl=%h", r);
    src = 4'h1;              // c = 66000: hit coincides with clear
    wr(2'd3, 32'h3);
    rd(2'd3, r);
    check("lost_clear_wins", r, 32'h0000_0001);
    src = 4'h2;              // c = 66001: counting resumes
    tick();
    rd(2'd3, r);
    check("lost_after_clear", r, 32'h0001_0001);
    $display("lost clear: ctrl=%h", r);
    src = 4'h0;
    tick();
    tick();

    // Reset while everything is active, with an edge in flight.
    src = 4'hF; tick();
    src = 4'h0; tick();
    wr(2'd1, 32'hF);
    tick();
    rd(2'd0, r);
    check("pre_rst_pending", r, 32'hF);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    src = 4'hF; tick();
    rst = 1'b1; src = 4'h0; tick();
    for (int s = 0; s < 4; s++) begin
      rd(2'(s), r);
      check($sformatf("midrst_reg%0d", s), r, 32'd0);
    end
    check("midrst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    tick();
    tick();
    rd(2'd0, r);
    check("post_rst_pending", r, 32'd0);
    check("post_rst_irq", {31'd0, irq}, 32'd0);
    $display("mid-operation reset: pending=%h irq=%b", r, irq);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller between the timer/IO peripherals and the pipelined CPU core's `INT` input; it replaces the direct counter-to-INT wire. It samples up to `N_SRC` level sources (counter0/1/2 outputs, button pulses), converts rising edges into sticky pending bits and applies a mask and a global enable. It drives a single registered `irq` line to the CPU. MIO_BUS decodes the address and gives the block a 2-bit register select plus a write strobe; software reads, masks and acknowledges interrupts through four 32-bit registers.

## Interface
- `N_SRC`, default 4: number of interrupt sources, 1..16; source 0 has the highest priority.
- `clk`  in  1  CPU/system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `src`  in  N_SRC  raw interrupt sources; may come from the inverted IO clock domain, so they are treated as asynchronous to `clk` phase.
- `we`  in  1  register write strobe from MIO_BUS.
- `reg_sel`  in  2  register select (bus addr[3:2]).
- `wdata`  in  32  write data from the CPU.
- `rdata`  out  32  read data of the selected register; combinational from registered state.
- `irq`  out  1  interrupt request to CPU `INT`; registered.

## Operation
- Register 0, PENDING:
  - Read returns pending[N_SRC-1:0], zero-extended.
  - Write is write-1-to-clear per bit.
- Register 1, MASK:
  - Read/write over bits [N_SRC-1:0]; upper bits read 0.
  - A bit value of 1 enables that source.
- Register 2, CAUSE:
  - Read-only; writes are ignored.
  - bit31 is 1 when any bit of (pending & mask) is set.
  - bits[3:0] give the index of the lowest-numbered set bit of (pending & mask); they read 0 when bit31 is 0.
- Register 3, CTRL:
  - bit0 is GIE, read/write.
  - bits[31:16] are LOST, a read-only 16-bit count.
  - Writing with wdata[1]=1 clears LOST; bit1 always reads 0.
- Edge detection: two-stage pipeline `s1 <= src; s2 <= s1`, with `rise = s1 & ~s2`.
- A `rise` bit sets the matching pending bit. The mask has no effect on pending; masked sources still latch.
- Set and clear in the same cycle on the same bit: set wins and the bit stays 1.
- LOST increments by 1 per cycle in which any `rise` bit hits an already-pending bit. Several bits hitting in one cycle still count as 1.
- LOST saturates at 0xFFFF.
- If a LOST clear and an increment fall on the same edge, the result is 0.
- `irq <= GIE & |(pending & mask)`.

## Timing
- Reset values while `rst` is high:
  - pending=0, mask=0, GIE=0, LOST=0.
  - `irq`=0; `rdata` reflects these zeros.
  - s1 and s2 both load `src`. A source held high across reset release therefore produces no edge.
- Latency: `src` first sampled high at edge t -> s1=1 after t -> pending set at t+1 -> `irq`=1 after t+2.
- A source pulse must be high for at least one `clk` rising edge to be seen. Pulses narrower than that may be missed, and that is acceptable.
- A write takes effect at the edge where `we`=1. `irq` reflects the write at the following edge (1-cycle lag).
  - Example: W1C of the last enabled pending bit at edge t -> `irq`=0 after t+1.
- Reads have zero latency: `rdata` follows `reg_sel` combinationally and shows state as of the last edge.
- Reset mid-operation: all state clears at the reset edge. An in-flight edge in s1/s2 is discarded.

## Test plan
- Reset, then hold src=4'b0001 high from reset release -> pending stays 0, `irq` stays 0 for 20 cycles.
- MASK=0x1, GIE=1; pulse src[0] for 1 cycle sampled at edge t -> PENDING=0x1 after t+1, `irq`=1 after t+2, CAUSE=0x8000_0000. Write PENDING=0x1 -> `irq`=0 one cycle later.
- MASK=0xF, GIE=1; raise src[2] and src[1] on the same edge -> PENDING=0x6, CAUSE=0x8000_0001. Clear bit1 -> CAUSE=0x8000_0002.
- MASK=0; raise src[3] -> PENDING=0x8, `irq`=0. Then write MASK=0x8 -> `irq`=1 one cycle after the write.
- Collisions on a pending bit:
  - Edge on pending bit 0 in the same cycle as a W1C of bit 0 -> bit stays 1, LOST=1.
  - Repeat this 70000 times -> LOST=0xFFFF.
  - Write CTRL with wdata=0x3 -> LOST=0, GIE=1.
- Assert `rst` for 1 cycle while PENDING=0xF, MASK=0xF, GIE=1, `irq`=1 -> all registers 0 and `irq`=0 after that edge.
